// File: rtl/e_mdu.sv
// E_MDU: multi-cycle multiply/divide unit with HI/LO registers for a MIPS-style execute stage.
// Optional macro E_MDU_DIV0_GUARD_EN: divide-by-zero leaves HI/LO untouched instead of writing them.
`timescale 1ns/1ps
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        E_start,
    input  logic [3:0]  E_mdu_op,
    input  logic [31:0] E_data1,
    input  logic [31:0] E_data2,
    output logic        E_busy,
    output logic [31:0] E_mdu_out
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [3:0]         r_op;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic signed [63:0] w_prod_s;
    logic [63:0]        w_prod_u;
    logic               w_div_signed;
    logic               w_den_zero;
    logic [31:0]        w_abs_a;
    logic [31:0]        w_abs_b;
    logic [31:0]        w_num;
    logic [31:0]        w_den;
    logic [31:0]        w_uq;
    logic [31:0]        w_ur;
    logic [31:0]        w_quot;
    logic [31:0]        w_rem;

    assign w_prod_s = $signed(r_a) * $signed(r_b);
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

    // Signed divide runs on magnitudes so that 0x80000000 / -1 wraps to 0x80000000 cleanly.
    assign w_div_signed = (r_op == OP_DIV);
    assign w_den_zero   = (r_b == 32'd0);
    assign w_abs_a      = r_a[31] ? (32'd0 - r_a) : r_a;
    assign w_abs_b      = r_b[31] ? (32'd0 - r_b) : r_b;
    assign w_num        = w_div_signed ? w_abs_a : r_a;
    assign w_den        = w_den_zero ? 32'd1 : (w_div_signed ? w_abs_b : r_b);
    assign w_uq         = w_num / w_den;
    assign w_ur         = w_num % w_den;
    assign w_quot       = (w_div_signed && (r_a[31] ^ r_b[31])) ? (32'd0 - w_uq) : w_uq;
    assign w_rem        = (w_div_signed && r_a[31]) ? (32'd0 - w_ur) : w_ur;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= 4'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (E_start) begin
                        case (E_mdu_op)
                            OP_MULT, OP_MULTU: begin
                                r_op    <= E_mdu_op;
                                r_a     <= E_data1;
                                r_b     <= E_data2;
                                r_cnt   <= CNT_W'(MULT_CYCLES);
                                r_state <= S_BUSY;
                            end
                            OP_DIV, OP_DIVU: begin
                                r_op    <= E_mdu_op;
                                r_a     <= E_data1;
                                r_b     <= E_data2;
                                r_cnt   <= CNT_W'(DIV_CYCLES);
                                r_state <= S_BUSY;
                            end
                            OP_MTHI: r_hi <= E_data1;
                            OP_MTLO: r_lo <= E_data1;
                            default: ;
                        endcase
                    end
                end
                S_BUSY: begin
                    // New starts are dropped here; the pipeline stalls on E_busy.
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_IDLE;
                        case (r_op)
                            OP_MULT: begin
                                r_hi <= w_prod_s[63:32];
                                r_lo <= w_prod_s[31:0];
                            end
                            OP_MULTU: begin
                                r_hi <= w_prod_u[63:32];
                                r_lo <= w_prod_u[31:0];
                            end
                            OP_DIV, OP_DIVU: begin
                                if (w_den_zero) begin
`ifdef E_MDU_DIV0_GUARD_EN
                                    r_hi <= r_hi;
                                    r_lo <= r_lo;
`else
                                    r_hi <= r_a;
                                    r_lo <= 32'hFFFF_FFFF;
`endif
                                end else begin
                                    r_hi <= w_rem;
                                    r_lo <= w_quot;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign E_busy = (r_state == S_BUSY);

    always_comb begin
        E_mdu_out = 32'd0;
        case (E_mdu_op)
            OP_MFHI: E_mdu_out = r_hi;
            OP_MFLO: E_mdu_out = r_lo;
            default: E_mdu_out = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_e_mdu.sv
// Directed self-checking bench for e_mdu: timing, arithmetic, HI/LO moves, reset and busy behaviour.
`timescale 1ns/1ps
module tb_e_mdu;

    logic        clk;
    logic        reset_n;
    logic        E_start;
    logic [3:0]  E_mdu_op;
    logic [31:0] E_data1;
    logic [31:0] E_data2;
    logic        E_busy;
    logic [31:0] E_mdu_out;

    int n_cmp  = 0;
    int n_fail = 0;

    e_mdu dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .E_start   (E_start),
        .E_mdu_op  (E_mdu_op),
        .E_data1   (E_data1),
        .E_data2   (E_data2),
        .E_busy    (E_busy),
        .E_mdu_out (E_mdu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Caller is at a negedge; the op is presented for exactly one rising edge.
    task automatic start_op(input logic [3:0] op, input logic [31:0] d1, input logic [31:0] d2);
        $display("start op=%0d d1=%h d2=%h", op, d1, d2);
        E_start  = 1'b1;
        E_mdu_op = op;
        E_data1  = d1;
        E_data2  = d2;
        @(negedge clk);
        E_start  = 1'b0;
        E_mdu_op = 4'd0;
        E_data1  = 32'hDEAD_BEEF;
        E_data2  = 32'hCAFE_F00D;
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        E_mdu_op = 4'd5;
        #1 hi = E_mdu_out;
        E_mdu_op = 4'd6;
        #1 lo = E_mdu_out;
        E_mdu_op = 4'd0;
        #1;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (E_busy === 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        logic [31:0] hi, lo;
        reset_n  = 1'b0;
        E_start  = 1'b0;
        E_mdu_op = 4'd0;
        E_data1  = 32'd0;
        E_data2  = 32'd0;
        #12;
        read_hilo(hi, lo);
        n_cmp++; if (E_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", E_busy); end
        n_cmp++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h expected 0", hi); end
        n_cmp++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h expected 0", lo); end
        @(negedge clk);
        reset_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_mthi_mtlo;
        logic [31:0] hi, lo;
        start_op(4'd7, 32'h1234_5678, 32'h0);
        n_cmp++; if (E_busy !== 1'b0) begin n_fail++; $display("FAIL mthi_busy: got %b expected 0", E_busy); end
        read_hilo(hi, lo);
        n_cmp++; if (hi !== 32'h1234_5678) begin n_fail++; $display("FAIL mthi_hi: got %h expected 12345678", hi); end
        n_cmp++; if (lo !== 32'h0) begin n_fail++; $display("FAIL mthi_lo_kept: got %h expected 0", lo); end
        @(negedge clk);
        start_op(4'd8, 32'h0BAD_F00D, 32'h0);
        n_cmp++; if (E_busy !== 1'b0) begin n_fail++; $display("FAIL mtlo_busy: got %b expected 0", E_busy); end
        read_hilo(hi, lo);
        n_cmp++; if (lo !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL mtlo_lo: got %h expected 0badf00d", lo); end
        n_cmp++; if (hi !== 32'h1234_5678) begin n_fail++; $display("FAIL mtlo_hi_kept: got %h expected 12345678", hi); end
        @(negedge clk);
    endtask

    task automatic test_nop_ops;
        logic [31:0] hi, lo;
        logic [3:0] ops [5];
        ops = '{4'd0, 4'd5, 4'd6, 4'd9, 4'd15};
        for (int i = 0; i < 5; i++) begin
            start_op(ops[i], 32'h5555_5555, 32'h7);
            n_cmp++; if (E_busy !== 1'b0) begin n_fail++; $display("FAIL nop_busy op=%0d: got %b expected 0", ops[i], E_busy); end
        end
        read_hilo(hi, lo);
        n_cmp++; if (hi !== 32'h1234_5678 || lo !== 32'h0BAD_F00D) begin
            n_fail++; $display("FAIL nop_hilo: got %h/%h expected 12345678/0badf00d", hi, lo);
        end
        @(negedge clk);
    endtask

    task automatic test_mult;
        logic [31:0] hi, lo;
        int c;
        start_op(4'd1, 32'hFFFF_FFFE, 32'h0000_0003);
        read_hilo(hi, lo);
        n_cmp++; if (hi !== 32'h1234_5678 || lo !== 32'h0BAD_F00D) begin
            n_fail++; $display("FAIL mult_preop_out: got %h/%h expected 12345678/0badf00d", hi, lo);
        end
        wait_done(c);
        n_cmp++; if (c !== 5) begin n_fail++; $display("FAIL mult_busy_len: got %0d expected 5", c); end
        read_hilo(hi, lo);
        n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
        n_cmp++; if (lo !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL mult_lo: got %h expected fffffffa", lo); end
        @(negedge clk);
        start_op(4'd2, 32'hFFFF_FFFE, 32'h0000_0003);
        wait_done(c);
        n_cmp++; if (c !== 5) begin n_fail++; $display("FAIL multu_busy_len: got %0d expected 5", c); end
        read_hilo(hi, lo);
        n_cmp++; if (hi !== 32'h0000_0002) begin n_fail++; $display("FAIL multu_hi: got %h expected 00000002", hi); end
        n_cmp++; if (lo !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL multu_lo: got %h expected fffffffa", lo); end
        @(negedge clk);
    endtask

    task automatic test_div;
        logic [31:0] hi, lo;
        int c;
        logic [3:0]  ops [4];
        logic [31:0] d1s [4];
        logic [31:0] d2s [4];
        logic [31:0] ehi [4];
        logic [31:0] elo [4];
        ops = '{4'd3, 4'd4, 4'd3, 4'd3};
        d1s = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd7};
        d2s = '{32'd2, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        ehi = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1};
        elo = '{32'hFFFF_FFFD, 32'd3, 32'h8000_0000, 32'hFFFF_FFFD};
        for (int i = 0; i < 4; i++) begin
            start_op(ops[i], d1s[i], d2s[i]);
            wait_done(c);
            n_cmp++; if (c !== 10) begin n_fail++; $display("FAIL div_busy_len[%0d]: got %0d expected 10", i, c); end
            read_hilo(hi, lo);
            n_cmp++; if (hi !== ehi[i]) begin n_fail++; $display("FAIL div_hi[%0d]: got %h expected %h", i, hi, ehi[i]); end
            n_cmp++; if (lo !== elo[i]) begin n_fail++; $display("FAIL div_lo[%0d]: got %h expected %h", i, lo, elo[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_div0;
        logic [31:0] hi, lo;
        int c;
        start_op(4'd7, 32'h0000_AAAA, 32'h0);
        start_op(4'd8, 32'h0000_BBBB, 32'h0);
        start_op(4'd3, 32'h0000_0064, 32'h0);
        wait_done(c);
        n_cmp++; if (c !== 10) begin n_fail++; $display("FAIL div0_busy_len: got %0d expected 10", c); end
        read_hilo(hi, lo);
`ifdef E_MDU_DIV0_GUARD_EN
        n_cmp++; if (hi !== 32'h0000_AAAA) begin n_fail++; $display("FAIL div0_hi: got %h expected 0000aaaa", hi); end
        n_cmp++; if (lo !== 32'h0000_BBBB) begin n_fail++; $display("FAIL div0_lo: got %h expected 0000bbbb", lo); end
`else
        n_cmp++; if (hi !== 32'h0000_0064) begin n_fail++; $display("FAIL div0_hi: got %h expected 00000064", hi); end
        n_cmp++; if (lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div0_lo: got %h expected ffffffff", lo); end
`endif
        @(negedge clk);
    endtask

    task automatic test_busy_ignore;
        logic [31:0] hi, lo;
        int c;
        start_op(4'd1, 32'd3, 32'd4);
        start_op(4'd1, 32'd5, 32'd6);
        start_op(4'd8, 32'h7777_7777, 32'd0);
        wait_done(c);
        n_cmp++; if (c + 2 !== 5) begin n_fail++; $display("FAIL ignore_busy_len: got %0d expected 5", c + 2); end
        read_hilo(hi, lo);
        n_cmp++; if (hi !== 32'd0) begin n_fail++; $display("FAIL ignore_hi: got %h expected 0", hi); end
        n_cmp++; if (lo !== 32'd12) begin n_fail++; $display("FAIL ignore_lo: got %h expected 0000000c", lo); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [31:0] hi, lo;
        int c;
        start_op(4'd2, 32'd7, 32'd6);
        wait_done(c);
        n_cmp++; if (c !== 5) begin n_fail++; $display("FAIL b2b_first_len: got %0d expected 5", c); end
        read_hilo(hi, lo);
        n_cmp++; if (lo !== 32'd42 || hi !== 32'd0) begin n_fail++; $display("FAIL b2b_first_res: got %h/%h expected 0/2a", hi, lo); end
        start_op(4'd4, 32'd100, 32'd7);
        n_cmp++; if (E_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got %b expected 1", E_busy); end
        wait_done(c);
        n_cmp++; if (c !== 10) begin n_fail++; $display("FAIL b2b_second_len: got %0d expected 10", c); end
        read_hilo(hi, lo);
        n_cmp++; if (hi !== 32'd2 || lo !== 32'd14) begin n_fail++; $display("FAIL b2b_second_res: got %h/%h expected 2/e", hi, lo); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic [31:0] hi, lo;
        start_op(4'd7, 32'h11, 32'h0);
        start_op(4'd8, 32'h22, 32'h0);
        start_op(4'd1, 32'd5, 32'd5);
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (E_busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_c3: got %b expected 1", E_busy); end
        #1 reset_n = 1'b0;
        #1;
        n_cmp++; if (E_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b expected 0", E_busy); end
        read_hilo(hi, lo);
        n_cmp++; if (hi !== 32'd0 || lo !== 32'd0) begin n_fail++; $display("FAIL rmid_hilo: got %h/%h expected 0/0", hi, lo); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        n_cmp++; if (E_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy_after: got %b expected 0", E_busy); end
        read_hilo(hi, lo);
        n_cmp++; if (hi !== 32'd0 || lo !== 32'd0) begin n_fail++; $display("FAIL rmid_hilo_after: got %h/%h expected 0/0", hi, lo); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_mthi_mtlo();
        test_nop_ops();
        test_mult();
        test_div();
        test_div0();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
